// File: rtl/sort_host.sv
// Host-side controller for an 8-entry external sorter: loads a batch of
// bytes, starts the sort, waits for completion and streams the result out.
module sort_host #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       s_wr,
  output logic [2:0] s_addr,
  output logic [7:0] s_datain,
  output logic       s_start,
  input  logic [7:0] s_dataout,
  input  logic       s_ready,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RD_ADDR,
    RD_CAP,
    EMIT
  } state_t;

  localparam logic [15:0] WLIM = 16'(WAIT_LIMIT - 1);

  state_t      state, state_nx;
  logic [2:0]  count, count_nx;
  logic [15:0] wcnt, wcnt_nx;
  logic [7:0]  data_q, data_nx;
  logic        valid_q, valid_nx;
  logic        last_q, last_nx;
  logic        tmo_q, tmo_nx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= LOAD;
      count   <= 3'd0;
      wcnt    <= 16'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      wcnt    <= wcnt_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      last_q  <= last_nx;
      tmo_q   <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    wcnt_nx  = wcnt;
    data_nx  = data_q;
    valid_nx = valid_q;
    last_nx  = last_q;
    tmo_nx   = tmo_q;
    in_ready = 1'b0;
    s_wr     = 1'b0;
    s_addr   = 3'd0;
    s_datain = 8'd0;
    s_start  = 1'b0;
    unique case (state)
      LOAD: begin
        // gated by nrst so the handshake is dead the instant reset asserts
        in_ready = s_ready & nrst;
        if (in_valid && in_ready) begin
          s_wr     = 1'b1;
          s_addr   = count;
          s_datain = in_data;
          tmo_nx   = 1'b0;
          if (count == 3'd7) begin
            count_nx = 3'd0;
            state_nx = START;
          end else begin
            count_nx = count + 3'd1;
          end
        end
      end
      START: begin
        s_start  = 1'b1;
        wcnt_nx  = 16'd0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!s_ready) begin
          wcnt_nx  = 16'd0;
          state_nx = WAIT_DONE;
        end else if (wcnt == 16'd3) begin
          state_nx = START;
        end else begin
          wcnt_nx = wcnt + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (s_ready) begin
          count_nx = 3'd0;
          wcnt_nx  = 16'd0;
          state_nx = RD_ADDR;
        end else if (wcnt >= WLIM) begin
          tmo_nx   = 1'b1;
          count_nx = 3'd0;
          wcnt_nx  = 16'd0;
          state_nx = LOAD;
        end else if (wcnt != 16'hFFFF) begin
          wcnt_nx = wcnt + 16'd1;
        end
      end
      RD_ADDR: begin
        s_addr   = count;
        state_nx = RD_CAP;
      end
      RD_CAP: begin
        data_nx  = s_dataout;
        valid_nx = 1'b1;
        last_nx  = (count == 3'd7);
        state_nx = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          last_nx  = 1'b0;
          if (count == 3'd7) begin
            count_nx = 3'd0;
            state_nx = LOAD;
          end else begin
            count_nx = count + 3'd1;
            state_nx = RD_ADDR;
          end
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign timeout   = tmo_q;
  assign busy      = !(state == LOAD && count == 3'd0);

endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host with a behavioural 8-entry sorter attached.
module tb_sort_host;

  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       s_wr, s_start, s_ready;
  logic [2:0] s_addr;
  logic [7:0] s_datain, s_dataout;
  logic       busy, timeout;
  logic       hang;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_host #(.WAIT_LIMIT(16)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_datain  (s_datain),
    .s_start   (s_start),
    .s_dataout (s_dataout),
    .s_ready   (s_ready),
    .busy      (busy),
    .timeout   (timeout)
  );

  // behavioural sorter
  logic [7:0] mem [8];
  int         m_cnt;

  function automatic logic [63:0] sort8(input logic [63:0] v);
    logic [7:0] a [8];
    logic [7:0] t;
    for (int i = 0; i < 8; i++) a[i] = v[63-8*i -: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 8; i++) sort8[63-8*i -: 8] = a[i];
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_ready   <= 1'b1;
      m_cnt     <= 0;
      s_dataout <= 8'd0;
    end else begin
      s_dataout <= mem[s_addr];
      if (s_ready) begin
        if (s_wr) mem[s_addr] <= s_datain;
        if (s_start) begin
          s_ready <= 1'b0;
          m_cnt   <= 4;
        end
      end else if (!hang) begin
        if (m_cnt != 0) m_cnt <= m_cnt - 1;
        else begin
          {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]} <=
            sort8({mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]});
          s_ready <= 1'b1;
        end
      end
    end
  end

  // monitor: output handshakes, sorter writes, start pulses
  logic [7:0] o_data [256];
  logic       o_last [256];
  int         o_cyc  [256];
  logic [2:0] wr_addr [256];
  int n_out = 0, n_wr = 0, starts = 0, cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nrst) begin
      if (out_valid && out_ready) begin
        o_data[n_out[7:0]] <= out_data;
        o_last[n_out[7:0]] <= out_last;
        o_cyc[n_out[7:0]]  <= cyc;
        n_out <= n_out + 1;
      end
      if (s_wr) begin
        wr_addr[n_wr[7:0]] <= s_addr;
        n_wr <= n_wr + 1;
      end
      if (s_start) starts <= starts + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_accept", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [63:0] v);
    for (int i = 0; i < 8; i++) send(v[63-8*i -: 8]);
  endtask

  task automatic wait_outs(input int target);
    int n = 0;
    while (n_out < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_outs", 32'(n_out >= target), 32'd1);
  endtask

  task automatic chk_batch(input string tag, input int base, input logic [63:0] exp);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", tag, i),
          {23'd0, o_last[base+i], o_data[base+i]},
          {23'd0, i == 7, exp[63-8*i -: 8]});
  endtask

  initial begin
    int base, wbase, st0, bad, n;
    logic [7:0] hold;

    nrst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;
    hang = 1'b0;
    #1;
    chk("rst_outs", {19'd0, in_ready, out_valid, out_last, s_wr, s_start, s_addr, busy, timeout},
        32'd0);
    chk("rst_data", {16'd0, out_data, s_datain}, 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // basic batch
    base = n_out; st0 = starts;
    send8(64'h05_03_08_01_07_02_06_04);
    wait_outs(base + 8);
    chk_batch("basic", base, 64'h01_02_03_04_05_06_07_08);
    chk("basic_starts", 32'(starts - st0), 32'd1);
    bad = 0;
    for (int i = 0; i < 7; i++)
      if (o_cyc[base+i+1] - o_cyc[base+i] != 3) bad++;
    chk("throughput", 32'(bad), 32'd0);

    // in_valid toggling
    base = n_out; wbase = n_wr;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'd80 - 8'(i * 10)));
      @(negedge clk);
    end
    bad = 0;
    while (n_out < base + 8 && bad < 1000) begin
      if (in_ready) bad += 1000;
      @(negedge clk);
      bad++;
    end
    chk("no_ready_during_batch", 32'(bad < 1000), 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (wr_addr[wbase+i] != 3'(i)) bad++;
    chk("wr_addr_order", 32'(bad), 32'd0);
    chk_batch("toggle", base, 64'h0A_14_1E_28_32_3C_46_50);
    chk("ready_after_batch", 32'(in_ready), 32'd1);

    // downstream stall on 3rd byte
    base = n_out;
    send8(64'h09_C8_32_00_FF_11_64_03);
    wait_outs(base + 2);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold = out_data;
    chk("stall_byte", 32'(hold), 32'h09);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== hold || out_valid !== 1'b1 || s_addr !== 3'd0) bad++;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    chk("stall_no_pop", 32'(n_out - base), 32'd2);
    out_ready = 1'b1;
    wait_outs(base + 8);
    chk_batch("stall", base, 64'h00_03_09_11_32_64_C8_FF);

    // sorter never completes
    hang = 1'b1;
    st0 = starts;
    send8(64'h01_02_03_04_05_06_07_08);
    n = 0;
    while (s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd17);
    chk("timeout_flag", 32'(timeout), 32'd1);
    chk("timeout_in_load", 32'(busy), 32'd0);
    chk("timeout_starts", 32'(starts - st0), 32'd1);
    hang = 1'b0;
    wbase = n_wr;
    send(8'h11);
    chk("timeout_cleared", 32'(timeout), 32'd0);
    chk("timeout_wr_addr", 32'(wr_addr[wbase]), 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // reset mid-load
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    chk("midload_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data = 8'h55;
    nrst = 1'b0;
    #1;
    chk("async_rst", {19'd0, in_ready, out_valid, out_last, s_wr, s_start, s_addr, busy, timeout},
        32'd0);
    chk("async_rst_data", {16'd0, out_data, s_datain}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
    base = n_out; wbase = n_wr; st0 = starts;
    send8(64'h3C_0A_FA_0A_00_63_01_80);
    chk("post_rst_addr0", 32'(wr_addr[wbase]), 32'd0);
    wait_outs(base + 8);
    chk_batch("post_rst", base, 64'h00_01_0A_0A_3C_63_80_FA);
    chk("post_rst_starts", 32'(starts - st0), 32'd1);

    // back-to-back batches
    base = n_out;
    send8(64'hAA_AA_AA_AA_AA_AA_AA_AA);
    send8(64'hFF_FE_FD_FC_FB_FA_F9_F8);
    wait_outs(base + 16);
    chk_batch("b2b_a", base, 64'hAA_AA_AA_AA_AA_AA_AA_AA);
    chk_batch("b2b_b", base + 8, 64'hF8_F9_FA_FB_FC_FD_FE_FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
